mems_dac_spi_seq: RTL
=====================

// Module: mems_dac_spi_seq
// PURPOSE
//  Sequencer/serializer for the MEMS mirror quad DAC. Drives the 4-bit address of the DAC command ROM,
//  captures each registered 24-bit command word, and shifts it out MSB-first on a 3-wire SPI
//  (sync_n/sclk/mosi), one frame per word. Sits directly downstream of the command ROM, feeding the DAC pins.
//  One start pulse sends a full init+update burst (addr 0..5) or an update-only burst (addr 2..5).
// PARAMETERS
//  CLK_DIV     2   clk cycles per SCLK half-period; legal range 1..255
//  GAP_CYCLES  4   clk cycles sync_n held high between frames; legal range 1..255
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous reset, active low
//  start       in   1   1-cycle pulse; begins a burst when idle
//  init        in   1   sampled with start: 1 = send words 0..5, 0 = send words 2..5
//  rom_addr    out  4   address to command ROM
//  rom_data    in   24  ROM output; valid 2 clk cycles after rom_addr changes (registered ROM)
//  spi_sync_n  out  1   DAC frame select, active low
//  spi_sclk    out  1   SPI clock, idles high
//  spi_mosi    out  1   serial data, MSB first
//  ldac_n      out  1   DAC load strobe, active low (see CONFIGURATION)
//  busy        out  1   high while a burst is in progress
//  done        out  1   1-cycle pulse at end of burst
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, rom_addr=0, spi_sync_n=1, spi_sclk=1, spi_mosi=0, ldac_n=1,
//   busy=0, done=0, shift register and counters cleared. Reset mid-frame aborts immediately; no partial resume.
//  States: IDLE -> FETCH -> SHIFT -> GAP -> (FETCH | LDAC | DONE) -> IDLE.
//  IDLE: start=1 -> latch init, rom_addr = init ? 0 : 2, busy=1 next cycle, go FETCH. start ignored when busy.
//  FETCH: wait exactly 2 cycles (ROM latency), then load rom_data into 24-bit shift reg, go SHIFT.
//  SHIFT: on entry cycle spi_sync_n=0, spi_mosi=bit23, spi_sclk=1. sclk toggles every CLK_DIV cycles:
//   first falling edge CLK_DIV cycles after sync_n falls; mosi updates on each rising edge (stable over
//   falling edge, where DAC samples). 24 falling edges per frame; sync_n low exactly 48*CLK_DIV cycles,
//   released together with the 24th rising edge; sclk ends high; mosi returns to 0.
//  GAP: sync_n high for GAP_CYCLES. If rom_addr==5 -> LDAC (macro on) or DONE; else rom_addr+1, FETCH.
//  DONE: done=1 for one cycle, busy=0 from next cycle, state IDLE. Back-to-back start on the cycle after done accepted.
//  rom_addr changes only in IDLE (on start) and at GAP exit; held stable during FETCH/SHIFT.
//  Bit counter 5 bits (0..23), divider counter 8 bits; no wrap beyond word 5 (addr never exceeds 5).
//  start and rst_n deassertion on the same edge: start ignored (reset recovery first).
// CONFIGURATION
//  MEMS_DAC_LDAC_PULSE_EN defined: after last GAP, state LDAC drives ldac_n=0 for 2*CLK_DIV cycles,
//   then DONE; all four DAC channels update simultaneously. Burst length grows by 2*CLK_DIV cycles.
//  Not defined: LDAC state absent, ldac_n tied 1; GAP of last word goes straight to DONE (DAC uses
//   software-LDAC setup from ROM word 1).
// TESTING
//  1 Reset: hold rst_n=0 mid-run -> sync_n=1, sclk=1, mosi=0, busy=0, ldac_n=1 within same cycle (async).
//  2 CLK_DIV=2, init=1, ROM words {0x280001,0x373FF0,0x02AA00,0x035500,0x00F000,0x110F00}: start ->
//    6 frames, SPI monitor decodes exactly those words in order, each frame 24 bits, sync_n low 96 cycles.
//  3 init=0, delta_A..D=0x80 -> 4 frames decoding 0x028000,0x038000,0x008000,0x118000; rom_addr 2..5 only.
//  4 start pulsed while busy (mid-frame 3) -> ignored; frame count and data unchanged, single done pulse.
//  5 start on cycle after done -> new burst begins; gap between bursts has sync_n high >= GAP_CYCLES.
//  6 MEMS_DAC_LDAC_PULSE_EN on, CLK_DIV=3: ldac_n low exactly 6 cycles after last sync_n rise+GAP,
//    before done; macro off: ldac_n constant 1 for entire burst.

Source files
------------

// File: rtl/mems_dac_spi_seq_if.sv
// Bundle of the command-ROM, control and DAC-pin signals of the MEMS DAC SPI sequencer.
// The slave modport is the sequencer; the master modport is the ROM/controller/DAC side.
`timescale 1ns/1ps
interface mems_dac_spi_seq_if;
   logic        start;
   logic        init;
   logic [3:0]  rom_addr;
   logic [23:0] rom_data;
   logic        spi_sync_n;
   logic        spi_sclk;
   logic        spi_mosi;
   logic        ldac_n;
   logic        busy;
   logic        done;

   modport master (
      output start, init, rom_data,
      input  rom_addr, spi_sync_n, spi_sclk, spi_mosi, ldac_n, busy, done
   );

   modport slave (
      input  start, init, rom_data,
      output rom_addr, spi_sync_n, spi_sclk, spi_mosi, ldac_n, busy, done
   );
endinterface

// File: rtl/mems_dac_spi_seq.sv
// MEMS mirror quad-DAC sequencer: walks ROM words 0..5 (or 2..5) and shifts each out as one SPI frame.
// Optional LDAC strobe after the last frame when MEMS_DAC_LDAC_PULSE_EN is defined.
`timescale 1ns/1ps
module mems_dac_spi_seq #(
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned GAP_CYCLES = 4
) (
   input logic               clk,
   input logic               rst_n,
   mems_dac_spi_seq_if.slave bus
);

   localparam logic [7:0] DivLast  = 8'(CLK_DIV - 1);
   localparam logic [7:0] GapLast  = 8'(GAP_CYCLES - 1);
   localparam logic [3:0] LastAddr = 4'd5;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StShift,
      StGap,
`ifdef MEMS_DAC_LDAC_PULSE_EN
      StLdac,
`endif
      StDone
   } state_e;

   state_e      state_q;
   logic [3:0]  rom_addr_q;
   logic [23:0] shift_q;
   logic [4:0]  bit_cnt_q;
   logic [7:0]  div_cnt_q;
   logic        sync_n_q;
   logic        sclk_q;
   logic        mosi_q;
   logic        busy_q;
   logic        done_q;
   logic        ready_q;
`ifdef MEMS_DAC_LDAC_PULSE_EN
   logic        ldac_n_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rom_addr_q <= 4'd0;
         shift_q    <= 24'd0;
         bit_cnt_q  <= 5'd0;
         div_cnt_q  <= 8'd0;
         sync_n_q   <= 1'b1;
         sclk_q     <= 1'b1;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ready_q    <= 1'b0;
`ifdef MEMS_DAC_LDAC_PULSE_EN
         ldac_n_q   <= 1'b1;
`endif
      end else begin
         // First edge after reset release only arms ready_q, so a start there is dropped.
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start && ready_q) begin
                  rom_addr_q <= bus.init ? 4'd0 : 4'd2;
                  busy_q     <= 1'b1;
                  div_cnt_q  <= 8'd0;
                  state_q    <= StFetch;
               end
            end
            StFetch: begin
               if (div_cnt_q == 8'd1) begin
                  // MSB goes straight to mosi; the rest waits in shift_q for the rising edges.
                  shift_q   <= {bus.rom_data[22:0], 1'b0};
                  mosi_q    <= bus.rom_data[23];
                  sync_n_q  <= 1'b0;
                  sclk_q    <= 1'b1;
                  div_cnt_q <= 8'd0;
                  bit_cnt_q <= 5'd0;
                  state_q   <= StShift;
               end else begin
                  div_cnt_q <= div_cnt_q + 8'd1;
               end
            end
            StShift: begin
               if (div_cnt_q == DivLast) begin
                  div_cnt_q <= 8'd0;
                  sclk_q    <= ~sclk_q;
                  if (!sclk_q) begin
                     if (bit_cnt_q == 5'd23) begin
                        sync_n_q <= 1'b1;
                        mosi_q   <= 1'b0;
                        state_q  <= StGap;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        mosi_q    <= shift_q[23];
                        shift_q   <= {shift_q[22:0], 1'b0};
                     end
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + 8'd1;
               end
            end
            StGap: begin
               if (div_cnt_q == GapLast) begin
                  div_cnt_q <= 8'd0;
                  if (rom_addr_q == LastAddr) begin
`ifdef MEMS_DAC_LDAC_PULSE_EN
                     ldac_n_q  <= 1'b0;
                     bit_cnt_q <= 5'd0;
                     state_q   <= StLdac;
`else
                     done_q    <= 1'b1;
                     state_q   <= StDone;
`endif
                  end else begin
                     rom_addr_q <= rom_addr_q + 4'd1;
                     state_q    <= StFetch;
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + 8'd1;
               end
            end
`ifdef MEMS_DAC_LDAC_PULSE_EN
            StLdac: begin
               // Two SCLK half-periods of low strobe; bit_cnt_q[0] marks the second half.
               if (div_cnt_q == DivLast) begin
                  div_cnt_q <= 8'd0;
                  if (bit_cnt_q[0]) begin
                     ldac_n_q <= 1'b1;
                     done_q   <= 1'b1;
                     state_q  <= StDone;
                  end else begin
                     bit_cnt_q <= 5'd1;
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + 8'd1;
               end
            end
`endif
            StDone: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.rom_addr   = rom_addr_q;
   assign bus.spi_sync_n = sync_n_q;
   assign bus.spi_sclk   = sclk_q;
   assign bus.spi_mosi   = mosi_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
`ifdef MEMS_DAC_LDAC_PULSE_EN
   assign bus.ldac_n     = ldac_n_q;
`else
   assign bus.ldac_n     = 1'b1;
`endif

endmodule
